// File: rtl/count_monitor_pkg.sv
// ---------------------------------------------------------------------------
// count_pkg
//   Shared definitions for the count_monitor slice: default widths, the width
//   of the internal good-increment counter and the monitor state encoding.
//   Imported by the interface, the top level and the saturating counter.
//
// Contents
//   DEF_WIDTH     default width of the monitored count value
//   DEF_ERR_W     default width of the saturating statistics counters
//   DEF_SYNC_LEN  default number of good increments needed to lock
//   GOOD_W        width of the good-increment counter (holds up to 7)
//   cmon_state_t  monitor states UNLOCKED / SYNC / LOCKED
// ---------------------------------------------------------------------------
package count_pkg;

    localparam int DEF_WIDTH    = 5;
    localparam int DEF_ERR_W    = 8;
    localparam int DEF_SYNC_LEN = 2;

    // SYNC_LEN is limited to 1..7, so three bits always hold the run length.
    localparam int GOOD_W = 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNC     = 2'd1,
        LOCKED   = 2'd2
    } cmon_state_t;

endpackage : count_pkg

// File: rtl/count_monitor_if.sv
// ---------------------------------------------------------------------------
// count_monitor_if
//   The count stream as seen between a free-running counter (producer) and
//   its consumer. The producer drives a new value plus a valid flag each
//   cycle; the consumer only looks at count_in when count_vld is high.
//
// Signals
//   count_in   [WIDTH]  current counter value
//   count_vld  [1]      count_in carries a sample this cycle
//
// Modports
//   master  producer side (drives the stream)
//   slave   consumer side (count_monitor)
// ---------------------------------------------------------------------------
interface count_monitor_if
#(
    parameter int WIDTH = count_pkg::DEF_WIDTH
) ();

    logic [WIDTH-1:0] count_in;
    logic             count_vld;

    modport master (
        output count_in,
        output count_vld
    );

    modport slave (
        input  count_in,
        input  count_vld
    );

endinterface : count_monitor_if

// File: rtl/count_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Small statistics counter used by count_monitor. Counts single-cycle
//   increment requests and sticks at all-ones instead of wrapping, so a
//   large event count never reads back as a small one.
//
// Parameters
//   W      counter width
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous, active-low reset (value -> 0)
//   clr    in   1   synchronous clear, has priority over inc
//   inc    in   1   add one this cycle unless already saturated
//   value  out  W   current count
// ---------------------------------------------------------------------------
module sat_counter
#(
    parameter int W = count_pkg::DEF_ERR_W
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic saturated;

    assign saturated = (value == '1);

    // Clear beats increment so a clear issued in the same cycle as an event
    // always leaves the counter at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !saturated) begin
            value <= value + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/count_monitor.sv
// ---------------------------------------------------------------------------
// count_monitor
//   Receive-side checker for a free-running up-counter stream (+1 per valid
//   sample, wrapping from all-ones to zero). The monitor locks onto the
//   stream after SYNC_LEN consecutive good increments, then flags every
//   sample that is not the previous one plus one. Errors and correct wraps
//   seen while locked are counted in saturating statistics counters.
//
// Parameters
//   WIDTH     width of the monitored count (modulus 2**WIDTH)
//   ERR_W     width of err_cnt / wrap_cnt
//   SYNC_LEN  good increments needed to enter LOCKED (1..7)
//
// Ports
//   clk         in   1      rising-edge clock, shared with the producer
//   rst         in   1      asynchronous, active-low reset
//   cnt_if      slave       count_in / count_vld stream
//   clr         in   1      synchronous clear of err_sticky, err_cnt, wrap_cnt
//   locked      out  1      monitor is in LOCKED
//   err_pulse   out  1      one-cycle pulse for a mismatch seen while LOCKED
//   err_sticky  out  1      set by any err_pulse, cleared by rst or clr
//   err_cnt     out  ERR_W  mismatches seen while LOCKED (saturating)
//   wrap_cnt    out  ERR_W  correct all-ones -> 0 steps while LOCKED (saturating)
//   exp_cap     out  WIDTH  expected value of the first error (optional)
//   obs_cap     out  WIDTH  observed value of the first error (optional)
//
// Configuration
//   COUNT_MONITOR_CAPTURE_EN  when defined, adds exp_cap / obs_cap, which
//   hold the expected and observed values of the first error since reset or
//   clr and stay frozen while err_sticky is set.
// ---------------------------------------------------------------------------
module count_monitor
    import count_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int SYNC_LEN = DEF_SYNC_LEN
)
(
    input  logic              clk,
    input  logic              rst,
    count_monitor_if.slave    cnt_if,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ERR_W-1:0]  wrap_cnt
`ifdef COUNT_MONITOR_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]  exp_cap,
    output logic [WIDTH-1:0]  obs_cap
`endif
);

    cmon_state_t       state;
    cmon_state_t       state_next;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  exp_val;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_next;
    logic              match;
    logic              is_wrap;
    logic              err_hit;
    logic              wrap_hit;

    // The expected value drops the carry, so all-ones is followed by zero.
    assign exp_val = prev + WIDTH'(1);
    assign match   = (cnt_if.count_in == exp_val);
    assign is_wrap = (prev == '1) && (cnt_if.count_in == '0);

    // locked is a straight decode of the state register, so it falls in the
    // same cycle that err_pulse rises.
    assign locked = (state == LOCKED);

    // Next-state logic. Only valid samples move the FSM; idle cycles leave
    // everything as it is. The first sample after reset is only captured as
    // a reference, since there is nothing yet to compare it with.
    always_comb begin
        state_next = state;
        good_next  = good;
        err_hit    = 1'b0;
        wrap_hit   = 1'b0;

        if (cnt_if.count_vld) begin
            case (state)
                UNLOCKED: begin
                    good_next  = '0;
                    state_next = SYNC;
                end

                SYNC: begin
                    if (match) begin
                        good_next = good + GOOD_W'(1);
                        if (good_next == GOOD_W'(SYNC_LEN)) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        // Not yet trusted, so a mismatch just restarts the run.
                        good_next = '0;
                    end
                end

                LOCKED: begin
                    if (match) begin
                        wrap_hit = is_wrap;
                    end else begin
                        err_hit    = 1'b1;
                        good_next  = '0;
                        state_next = SYNC;
                    end
                end

                default: begin
                    good_next  = '0;
                    state_next = UNLOCKED;
                end
            endcase
        end
    end

    // State, run length and reference value. prev follows every valid
    // sample, good or bad, so a resync starts from the value just seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNLOCKED;
            good  <= '0;
            prev  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
            if (cnt_if.count_vld) begin
                prev <= cnt_if.count_in;
            end
        end
    end

    // Error flags. The pulse ignores clr so software always sees the event,
    // while the sticky flag gives clr priority over a simultaneous error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_pulse <= err_hit;
            if (clr) begin
                err_sticky <= 1'b0;
            end else if (err_hit) begin
                err_sticky <= 1'b1;
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (err_hit),
        .value (err_cnt)
    );

    sat_counter #(.W(ERR_W)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (wrap_hit),
        .value (wrap_cnt)
    );

`ifdef COUNT_MONITOR_CAPTURE_EN
    // First-error capture. err_sticky is still low on the cycle of the first
    // error, which arms the load; after that the values are frozen until clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_cap <= '0;
            obs_cap <= '0;
        end else if (clr) begin
            exp_cap <= '0;
            obs_cap <= '0;
        end else if (err_hit && !err_sticky) begin
            exp_cap <= exp_val;
            obs_cap <= cnt_if.count_in;
        end
    end
`else
    // Without the capture option no capture registers are built.
`endif

endmodule : count_monitor

// File: tb/tb_count_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_monitor
//   Self-checking bench for count_monitor. Two instances share one stream:
//   dut_a with default widths and dut_b with 2-bit statistics so saturation
//   is reached quickly. A behavioural model follows the monitor's rules with
//   plain integers; a directed table, a few hand-written sequences and a
//   randomized stream are all compared against it.
//   Define COUNT_MONITOR_CAPTURE_EN to also cover exp_cap / obs_cap.
// ---------------------------------------------------------------------------
module tb_count_monitor;
    import count_pkg::*;

    localparam int W_TB    = 5;
    localparam int MOD     = 1 << W_TB;
    localparam int SYNC_TB = 2;
    localparam int MAX_A   = 255;
    localparam int MAX_B   = 3;

    logic clk;
    logic rst;
    logic clr;

    count_monitor_if #(.WIDTH(W_TB)) bus ();

    logic       locked_a, err_pulse_a, err_sticky_a;
    logic [7:0] err_cnt_a, wrap_cnt_a;
    logic       locked_b, err_pulse_b, err_sticky_b;
    logic [1:0] err_cnt_b, wrap_cnt_b;
`ifdef COUNT_MONITOR_CAPTURE_EN
    logic [4:0] exp_cap_a, obs_cap_a;
    logic [4:0] exp_cap_b, obs_cap_b;
`endif

    count_monitor #(.WIDTH(W_TB), .ERR_W(8), .SYNC_LEN(SYNC_TB)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .cnt_if     (bus),
        .clr        (clr),
        .locked     (locked_a),
        .err_pulse  (err_pulse_a),
        .err_sticky (err_sticky_a),
        .err_cnt    (err_cnt_a),
        .wrap_cnt   (wrap_cnt_a)
`ifdef COUNT_MONITOR_CAPTURE_EN
        ,
        .exp_cap    (exp_cap_a),
        .obs_cap    (obs_cap_a)
`endif
    );

    count_monitor #(.WIDTH(W_TB), .ERR_W(2), .SYNC_LEN(SYNC_TB)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .cnt_if     (bus),
        .clr        (clr),
        .locked     (locked_b),
        .err_pulse  (err_pulse_b),
        .err_sticky (err_sticky_b),
        .err_cnt    (err_cnt_b),
        .wrap_cnt   (wrap_cnt_b)
`ifdef COUNT_MONITOR_CAPTURE_EN
        ,
        .exp_cap    (exp_cap_b),
        .obs_cap    (obs_cap_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the reference value, how many good steps since the
    // last (re)start, lock flag and unbounded event totals.
    bit m_have_ref;
    int m_prev;
    int m_run;
    bit m_locked;
    bit m_pulse;
    bit m_sticky;
    int m_errs;
    int m_wraps;
`ifdef COUNT_MONITOR_CAPTURE_EN
    int m_exp_cap;
    int m_obs_cap;
`endif

    typedef struct {
        bit         rst;
        bit         vld;
        logic [4:0] val;
        bit         clr;
        bit         e_locked;
        bit         e_pulse;
        bit         e_sticky;
        int         e_err;
        int         e_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check_int(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_have_ref = 1'b0;
        m_prev     = 0;
        m_run      = 0;
        m_locked   = 1'b0;
        m_pulse    = 1'b0;
        m_sticky   = 1'b0;
        m_errs     = 0;
        m_wraps    = 0;
`ifdef COUNT_MONITOR_CAPTURE_EN
        m_exp_cap  = 0;
        m_obs_cap  = 0;
`endif
    endtask

    task automatic modelStep(input bit v, input int d, input bit c);
        int expect_v;
        expect_v = (m_prev + 1) % MOD;
        m_pulse  = 1'b0;
        if (v) begin
            if (!m_have_ref) begin
                m_have_ref = 1'b1;
                m_run      = 0;
            end else if (m_locked) begin
                if (d == expect_v) begin
                    if (d == 0) m_wraps++;
                end else begin
                    m_pulse  = 1'b1;
                    m_errs++;
                    m_locked = 1'b0;
                    m_run    = 0;
`ifdef COUNT_MONITOR_CAPTURE_EN
                    if (!m_sticky) begin
                        m_exp_cap = expect_v;
                        m_obs_cap = d;
                    end
`endif
                    m_sticky = 1'b1;
                end
            end else begin
                if (d == expect_v) begin
                    m_run++;
                    if (m_run == SYNC_TB) m_locked = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
            m_prev = d;
        end
        if (c) begin
            m_errs   = 0;
            m_wraps  = 0;
            m_sticky = 1'b0;
`ifdef COUNT_MONITOR_CAPTURE_EN
            m_exp_cap = 0;
            m_obs_cap = 0;
`endif
        end
    endtask

    task automatic checkOutput();
        check_int("a.locked",   int'(locked_a),     int'(m_locked));
        check_int("a.pulse",    int'(err_pulse_a),  int'(m_pulse));
        check_int("a.sticky",   int'(err_sticky_a), int'(m_sticky));
        check_int("a.err_cnt",  int'(err_cnt_a),    sat(m_errs, MAX_A));
        check_int("a.wrap_cnt", int'(wrap_cnt_a),   sat(m_wraps, MAX_A));
        check_int("b.locked",   int'(locked_b),     int'(m_locked));
        check_int("b.pulse",    int'(err_pulse_b),  int'(m_pulse));
        check_int("b.sticky",   int'(err_sticky_b), int'(m_sticky));
        check_int("b.err_cnt",  int'(err_cnt_b),    sat(m_errs, MAX_B));
        check_int("b.wrap_cnt", int'(wrap_cnt_b),   sat(m_wraps, MAX_B));
`ifdef COUNT_MONITOR_CAPTURE_EN
        check_int("a.exp_cap",  int'(exp_cap_a),    m_exp_cap);
        check_int("a.obs_cap",  int'(obs_cap_a),    m_obs_cap);
        check_int("b.exp_cap",  int'(exp_cap_b),    m_exp_cap);
        check_int("b.obs_cap",  int'(obs_cap_b),    m_obs_cap);
`endif
    endtask

    // Drive one cycle of inputs (just after an edge), let the next edge take
    // them, advance the model and compare shortly after that edge.
    task automatic applyStimulus(input bit r, input bit v, input logic [4:0] d, input bit c);
        rst           = r;
        bus.count_vld = v;
        bus.count_in  = d;
        clr           = c;
        @(posedge clk);
        if (!r) modelReset();
        else    modelStep(v, int'(d), c);
        #1;
        checkOutput();
    endtask

    task automatic addVector(input bit r, input bit v, input int d, input bit c,
                             input bit l, input bit p, input bit s, input int e, input int w);
        vec_t x;
        x.rst      = r;
        x.vld      = v;
        x.val      = 5'(d);
        x.clr      = c;
        x.e_locked = l;
        x.e_pulse  = p;
        x.e_sticky = s;
        x.e_err    = e;
        x.e_wrap   = w;
        vecs.push_back(x);
    endtask

    task automatic sendValid(input int d);
        applyStimulus(1'b1, 1'b1, 5'(d), 1'b0);
    endtask

    int v;
    int producer;
    int d_rand;
    bit r_rand;
    bit v_rand;
    bit c_rand;

    initial begin
        rst           = 1'b0;
        clr           = 1'b0;
        bus.count_vld = 1'b0;
        bus.count_in  = '0;
        modelReset();

        //         rst vld val clr  lock pulse stick err wrap
        // reset, clean stream 0..6, error at 9, relock on 10,11
        addVector(0, 0,  0, 0,   0, 0, 0, 0, 0);
        addVector(0, 0,  0, 0,   0, 0, 0, 0, 0);
        addVector(0, 0,  0, 0,   0, 0, 0, 0, 0);
        addVector(1, 0,  0, 0,   0, 0, 0, 0, 0);
        addVector(1, 1,  0, 0,   0, 0, 0, 0, 0);
        addVector(1, 1,  1, 0,   0, 0, 0, 0, 0);
        addVector(1, 1,  2, 0,   1, 0, 0, 0, 0);
        addVector(1, 1,  3, 0,   1, 0, 0, 0, 0);
        addVector(1, 1,  4, 0,   1, 0, 0, 0, 0);
        addVector(1, 1,  5, 0,   1, 0, 0, 0, 0);
        addVector(1, 1,  6, 0,   1, 0, 0, 0, 0);
        addVector(1, 1,  9, 0,   0, 1, 1, 1, 0);
        addVector(1, 1, 10, 0,   0, 0, 1, 1, 0);
        addVector(1, 1, 11, 0,   1, 0, 1, 1, 0);
        // reset, lock on 5,6,7, four idle cycles with garbage, then 8
        addVector(0, 0,  0, 0,   0, 0, 0, 0, 0);
        addVector(1, 1,  5, 0,   0, 0, 0, 0, 0);
        addVector(1, 1,  6, 0,   0, 0, 0, 0, 0);
        addVector(1, 1,  7, 0,   1, 0, 0, 0, 0);
        addVector(1, 0, 20, 0,   1, 0, 0, 0, 0);
        addVector(1, 0, 20, 0,   1, 0, 0, 0, 0);
        addVector(1, 0, 20, 0,   1, 0, 0, 0, 0);
        addVector(1, 0, 20, 0,   1, 0, 0, 0, 0);
        addVector(1, 1,  8, 0,   1, 0, 0, 0, 0);
        // reset, lock on 28..30, wrap 31 -> 0, then clr clears wrap_cnt
        addVector(0, 0,  0, 0,   0, 0, 0, 0, 0);
        addVector(1, 1, 28, 0,   0, 0, 0, 0, 0);
        addVector(1, 1, 29, 0,   0, 0, 0, 0, 0);
        addVector(1, 1, 30, 0,   1, 0, 0, 0, 0);
        addVector(1, 1, 31, 0,   1, 0, 0, 0, 0);
        addVector(1, 1,  0, 0,   1, 0, 0, 0, 1);
        addVector(1, 1,  1, 0,   1, 0, 0, 0, 1);
        addVector(1, 1,  2, 1,   1, 0, 0, 0, 0);

        $display("[TB] directed table: %0d vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].val, vecs[i].clr);
            check_int($sformatf("vec%0d.locked", i), int'(locked_a),     int'(vecs[i].e_locked));
            check_int($sformatf("vec%0d.pulse", i),  int'(err_pulse_a),  int'(vecs[i].e_pulse));
            check_int($sformatf("vec%0d.sticky", i), int'(err_sticky_a), int'(vecs[i].e_sticky));
            check_int($sformatf("vec%0d.err", i),    int'(err_cnt_a),    vecs[i].e_err);
            check_int($sformatf("vec%0d.wrap", i),   int'(wrap_cnt_a),   vecs[i].e_wrap);
        end

        // Saturation on the 2-bit instance, then clr together with an error.
        $display("[TB] saturation and clr priority");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        v = 0;
        sendValid(v);
        sendValid(v + 1);
        sendValid(v + 2);
        v = 2;
        for (int k = 0; k < 5; k++) begin
            v = (v + 5) % MOD;
            sendValid(v);
            check_int("sat.pulse", int'(err_pulse_a), 1);
            v = (v + 1) % MOD;
            sendValid(v);
            v = (v + 1) % MOD;
            sendValid(v);
            check_int("sat.relock", int'(locked_a), 1);
        end
        check_int("sat.err_b", int'(err_cnt_b), 3);
        check_int("sat.err_a", int'(err_cnt_a), 5);
        v = (v + 5) % MOD;
        applyStimulus(1'b1, 1'b1, 5'(v), 1'b1);
        check_int("clr.err_b",    int'(err_cnt_b),    0);
        check_int("clr.err_a",    int'(err_cnt_a),    0);
        check_int("clr.pulse_b",  int'(err_pulse_b),  1);
        check_int("clr.sticky_b", int'(err_sticky_b), 0);
        check_int("clr.locked_b", int'(locked_b),     0);

`ifdef COUNT_MONITOR_CAPTURE_EN
        // First-error capture, frozen on the second error, cleared by clr.
        $display("[TB] first-error capture");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        sendValid(1);
        sendValid(2);
        sendValid(3);
        sendValid(4);
        sendValid(12);
        check_int("cap.exp", int'(exp_cap_a), 5);
        check_int("cap.obs", int'(obs_cap_a), 12);
        sendValid(13);
        sendValid(14);
        sendValid(20);
        check_int("cap.err2",      int'(err_cnt_a), 2);
        check_int("cap.exp_held",  int'(exp_cap_a), 5);
        check_int("cap.obs_held",  int'(obs_cap_a), 12);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1);
        check_int("cap.exp_clr",   int'(exp_cap_a), 0);
        check_int("cap.obs_clr",   int'(obs_cap_a), 0);
`endif

        // Asynchronous reset in the middle of a locked stream with an error
        // already counted; the next sample after release is a fresh start.
        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        sendValid(10);
        sendValid(11);
        sendValid(12);
        sendValid(25);
        sendValid(26);
        sendValid(27);
        check_int("arst.pre_locked", int'(locked_a),  1);
        check_int("arst.pre_err",    int'(err_cnt_a), 1);
        #3;
        rst = 1'b0;
        modelReset();
        #1;
        check_int("arst.locked", int'(locked_a),     0);
        check_int("arst.sticky", int'(err_sticky_a), 0);
        check_int("arst.err",    int'(err_cnt_a),    0);
        @(posedge clk);
        #1;
        sendValid(17);
        check_int("arst.fresh_pulse",  int'(err_pulse_a), 0);
        check_int("arst.fresh_locked", int'(locked_a),    0);
        sendValid(18);
        sendValid(19);
        check_int("arst.relocked", int'(locked_a), 1);

        // Randomized stream: mostly clean increments with idle gaps, glitches,
        // producer restarts, occasional clr and rare resets.
        $display("[TB] randomized stream");
        producer = 19;
        for (int n = 0; n < 3000; n++) begin
            r_rand = ($urandom_range(0, 299) != 0);
            v_rand = ($urandom_range(0, 3) != 0);
            c_rand = ($urandom_range(0, 39) == 0);
            if (v_rand) begin
                if ($urandom_range(0, 49) == 0) producer = 0;
                else                            producer = (producer + 1) % MOD;
                d_rand = producer;
                if ($urandom_range(0, 11) == 0) d_rand = int'($urandom_range(0, MOD - 1));
            end else begin
                d_rand = int'($urandom_range(0, MOD - 1));
            end
            applyStimulus(r_rand, v_rand, 5'(d_rand), c_rand);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_count_monitor
